// File: rtl/exception_unit.sv
// Exception / interrupt controller: arbitrates invalid-opcode and external
// interrupt causes, raises a single non-nesting exception towards the
// datapath, and acknowledges the served interrupt source.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no exception outstanding; causes are evaluated every edge
// REQ     | Exc raised, cause frozen in EStatus, waiting for ExcAck
// HANDLER | handler running, no nesting, waiting for ERet
module exception_unit #(
    parameter int N_IRQ     = 4,
    parameter int ESTATUS_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_IRQ-1:0]     ExtIRQ,
    input  logic                 InvOp,
    input  logic                 ExcAck,
    input  logic                 ERet,
    input  logic                 IrqEnWe,
    input  logic [N_IRQ-1:0]     IrqEnD,
    output logic                 Exc,
    output logic [ESTATUS_W-1:0] EStatus,
    output logic [N_IRQ-1:0]     ExtIAck,
    output logic                 InHandler,
    output logic [N_IRQ-1:0]     IrqEn
);

    localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HANDLER = 2'd2
    } state_t;

    state_t               state_q, state_nxt;
    logic [N_IRQ-1:0]     pending_q, pending_nxt;
    logic [N_IRQ-1:0]     irq_en_q, irq_en_nxt;
    logic [ESTATUS_W-1:0] estatus_q, estatus_nxt;
    logic [N_IRQ-1:0]     ext_iack_q, ext_iack_nxt;
    logic                 exc_q, exc_nxt;
    logic                 in_handler_q, in_handler_nxt;
    // The served IRQ index is kept on its own so the ack/clear path does not
    // need to pick bits back out of the cause code.
    logic                 irq_cause_q, irq_cause_nxt;
    logic [IDX_W-1:0]     irq_idx_q, irq_idx_nxt;

    logic [N_IRQ-1:0]     candidates;
    logic [N_IRQ-1:0]     clr_mask;
    logic                 irq_found;
    logic [IDX_W-1:0]     irq_sel;
    logic [ESTATUS_W-1:0] irq_code;

    // State and output registers; every output is a plain flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            irq_en_q     <= '1;
            estatus_q    <= '0;
            ext_iack_q   <= '0;
            exc_q        <= 1'b0;
            in_handler_q <= 1'b0;
            irq_cause_q  <= 1'b0;
            irq_idx_q    <= '0;
        end else begin
            state_q      <= state_nxt;
            pending_q    <= pending_nxt;
            irq_en_q     <= irq_en_nxt;
            estatus_q    <= estatus_nxt;
            ext_iack_q   <= ext_iack_nxt;
            exc_q        <= exc_nxt;
            in_handler_q <= in_handler_nxt;
            irq_cause_q  <= irq_cause_nxt;
            irq_idx_q    <= irq_idx_nxt;
        end
    end

    // Next-state, cause arbitration, pending bookkeeping and next outputs.
    always_comb begin
        state_nxt     = state_q;
        estatus_nxt   = estatus_q;
        irq_cause_nxt = irq_cause_q;
        irq_idx_nxt   = irq_idx_q;
        ext_iack_nxt  = '0;
        clr_mask      = '0;
        irq_en_nxt    = IrqEnWe ? IrqEnD : irq_en_q;

        // A line sampled high this edge counts immediately, so Exc can rise
        // one cycle after a single-cycle pulse. The enable used is the one
        // in force before any write on this edge.
        candidates = (pending_q | (ExtIRQ & irq_en_q)) & irq_en_q;

        irq_found = 1'b0;
        irq_sel   = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (candidates[i] && !irq_found) begin
                irq_found = 1'b1;
                irq_sel   = IDX_W'(i);
            end
        end

        irq_code                = '0;
        irq_code[ESTATUS_W-1]   = 1'b1;
        irq_code[IDX_W-1:0]     = irq_sel;

        case (state_q)
            IDLE: begin
                if (InvOp) begin
                    estatus_nxt   = ESTATUS_W'(1);
                    irq_cause_nxt = 1'b0;
                    state_nxt     = REQ;
                end else if (irq_found) begin
                    estatus_nxt   = irq_code;
                    irq_cause_nxt = 1'b1;
                    irq_idx_nxt   = irq_sel;
                    state_nxt     = REQ;
                end
            end
            REQ: begin
                // ExcAck wins over a simultaneous ERet since ERet is ignored here.
                if (ExcAck) begin
                    state_nxt = HANDLER;
                    if (irq_cause_q) begin
                        for (int i = 0; i < N_IRQ; i++) begin
                            if (irq_idx_q == IDX_W'(i)) begin
                                clr_mask[i]     = 1'b1;
                                ext_iack_nxt[i] = 1'b1;
                            end
                        end
                    end
                end
            end
            HANDLER: begin
                if (ERet) begin
                    state_nxt     = IDLE;
                    estatus_nxt   = '0;
                    irq_cause_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Clear beats set: a still-high line re-pends on the following edge.
        pending_nxt    = (pending_q | (ExtIRQ & irq_en_q)) & ~clr_mask;
        exc_nxt        = (state_nxt == REQ);
        in_handler_nxt = (state_nxt == HANDLER);
    end

    assign Exc       = exc_q;
    assign EStatus   = estatus_q;
    assign ExtIAck   = ext_iack_q;
    assign InHandler = in_handler_q;
    assign IrqEn     = irq_en_q;

endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit with N_IRQ=4, ESTATUS_W=4.
module tb_exception_unit;

    logic       clk;
    logic       reset;
    logic [3:0] ExtIRQ;
    logic       InvOp;
    logic       ExcAck;
    logic       ERet;
    logic       IrqEnWe;
    logic [3:0] IrqEnD;
    logic       Exc;
    logic [3:0] EStatus;
    logic [3:0] ExtIAck;
    logic       InHandler;
    logic [3:0] IrqEn;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic       exc;
        logic [3:0] es;
        logic [3:0] iack;
        logic       inh;
        logic [3:0] en;
    } exp_t;

    exp_t sb[$];

    exception_unit #(.N_IRQ(4), .ESTATUS_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .ExtIRQ    (ExtIRQ),
        .InvOp     (InvOp),
        .ExcAck    (ExcAck),
        .ERet      (ERet),
        .IrqEnWe   (IrqEnWe),
        .IrqEnD    (IrqEnD),
        .Exc       (Exc),
        .EStatus   (EStatus),
        .ExtIAck   (ExtIAck),
        .InHandler (InHandler),
        .IrqEn     (IrqEn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_out(input string tag, input logic exc, input logic [3:0] es,
                              input logic [3:0] iack, input logic inh, input logic [3:0] en);
        exp_t e;
        e.tag  = tag;
        e.exc  = exc;
        e.es   = es;
        e.iack = iack;
        e.inh  = inh;
        e.en   = en;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert ({Exc, EStatus, ExtIAck, InHandler, IrqEn} === {e.exc, e.es, e.iack, e.inh, e.en})
            else begin
                errors++;
                $error("FAIL %s: observed exc=%0b es=%b iack=%b inh=%0b en=%b expected exc=%0b es=%b iack=%b inh=%0b en=%b",
                       e.tag, Exc, EStatus, ExtIAck, InHandler, IrqEn,
                       e.exc, e.es, e.iack, e.inh, e.en);
            end
        end
    endtask

    // Push the expectation for the outputs after the next edge, clock, compare.
    task automatic step(input string tag, input logic exc, input logic [3:0] es,
                        input logic [3:0] iack, input logic inh, input logic [3:0] en);
        expect_out(tag, exc, es, iack, inh, en);
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        reset   = 1'b1;
        ExtIRQ  = 4'b0000;
        InvOp   = 1'b0;
        ExcAck  = 1'b0;
        ERet    = 1'b0;
        IrqEnWe = 1'b0;
        IrqEnD  = 4'b0000;

        // Reset values before any clock edge.
        #3;
        expect_out("reset_async", 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111);
        drain();
        reset = 1'b0;
        step("idle_after_reset", 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111);

        // Single IRQ2 pulse.
        ExtIRQ = 4'b0100;
        step("irq2_req", 1'b1, 4'b1010, 4'b0000, 1'b0, 4'b1111);
        ExtIRQ = 4'b0000;
        step("irq2_req_hold", 1'b1, 4'b1010, 4'b0000, 1'b0, 4'b1111);
        ExcAck = 1'b1;
        step("irq2_ack", 1'b0, 4'b1010, 4'b0100, 1'b1, 4'b1111);
        ExcAck = 1'b0;
        step("irq2_iack_one_cycle", 1'b0, 4'b1010, 4'b0000, 1'b1, 4'b1111);
        ERet = 1'b1;
        step("irq2_eret", 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111);
        ERet   = 1'b0;
        ExcAck = 1'b1;
        step("ack_in_idle_ignored", 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111);
        ExcAck = 1'b0;

        // InvOp beats IRQ0 raised in the same cycle.
        InvOp  = 1'b1;
        ExtIRQ = 4'b0001;
        step("invop_first", 1'b1, 4'b0001, 4'b0000, 1'b0, 4'b1111);
        InvOp  = 1'b0;
        ExtIRQ = 4'b0000;
        ERet   = 1'b1;
        step("eret_in_req_ignored", 1'b1, 4'b0001, 4'b0000, 1'b0, 4'b1111);
        ERet   = 1'b0;
        ExcAck = 1'b1;
        step("invop_ack_no_iack", 1'b0, 4'b0001, 4'b0000, 1'b1, 4'b1111);
        ExcAck = 1'b0;
        ERet   = 1'b1;
        step("invop_eret", 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111);
        ERet = 1'b0;
        step("irq0_reassert", 1'b1, 4'b1000, 4'b0000, 1'b0, 4'b1111);
        ExcAck = 1'b1;
        ERet   = 1'b1;
        step("ack_and_eret_is_ack", 1'b0, 4'b1000, 4'b0001, 1'b1, 4'b1111);
        ExcAck = 1'b0;
        step("irq0_eret", 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111);
        ERet = 1'b0;
        step("idle_quiet_1", 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111);

        // Two lines in one pulse are served lowest index first.
        ExtIRQ = 4'b1010;
        step("order_irq1_req", 1'b1, 4'b1001, 4'b0000, 1'b0, 4'b1111);
        ExtIRQ = 4'b0000;
        step("order_irq1_hold", 1'b1, 4'b1001, 4'b0000, 1'b0, 4'b1111);
        ExcAck = 1'b1;
        step("order_irq1_ack", 1'b0, 4'b1001, 4'b0010, 1'b1, 4'b1111);
        ExcAck = 1'b0;
        ERet   = 1'b1;
        step("order_irq1_eret", 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111);
        ERet = 1'b0;
        step("order_irq3_req", 1'b1, 4'b1011, 4'b0000, 1'b0, 4'b1111);
        ExcAck = 1'b1;
        step("order_irq3_ack", 1'b0, 4'b1011, 4'b1000, 1'b1, 4'b1111);
        ExcAck = 1'b0;
        ERet   = 1'b1;
        step("order_irq3_eret", 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111);
        ERet = 1'b0;
        step("idle_quiet_2", 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111);

        // Masked line held high, then unmasked.
        IrqEnWe = 1'b1;
        IrqEnD  = 4'b1110;
        step("mask_write", 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1110);
        IrqEnWe = 1'b0;
        ExtIRQ  = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            step("masked_no_exc", 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1110);
        end
        IrqEnWe = 1'b1;
        IrqEnD  = 4'b1111;
        step("unmask_write", 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111);
        IrqEnWe = 1'b0;
        step("unmask_req", 1'b1, 4'b1000, 4'b0000, 1'b0, 4'b1111);
        ExtIRQ = 4'b0000;
        ExcAck = 1'b1;
        step("unmask_ack", 1'b0, 4'b1000, 4'b0001, 1'b1, 4'b1111);
        ExcAck = 1'b0;
        ERet   = 1'b1;
        step("unmask_eret", 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111);
        ERet = 1'b0;
        step("idle_quiet_3", 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111);

        // Reset while in REQ with two lines pending; mask write must be undone.
        ExtIRQ  = 4'b0110;
        IrqEnWe = 1'b1;
        IrqEnD  = 4'b1110;
        step("pre_reset_req", 1'b1, 4'b1001, 4'b0000, 1'b0, 4'b1110);
        ExtIRQ  = 4'b0000;
        IrqEnWe = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        expect_out("reset_mid_req", 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111);
        drain();
        #2;
        reset = 1'b0;
        step("post_reset_1", 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111);
        step("post_reset_2", 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111);
        step("post_reset_3", 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
